addr_seq: RTL and testbench

Sequencer that drives the 7-bit `addr_serial_num` into `addr_sel` for the 64-bit 8x8 systolic array. On a `start` pulse it issues a programmed range of serial numbers in steps of 4, one per cycle, pausing while the array back-pressures with `stall`. After the last issue it waits a fixed drain period so that operands can flush through `addr_sel`'s registered outputs and the array skew. It then pulses `done`.

---
 rtl/addr_seq_pkg.sv | 25 ++
 rtl/drain_cnt.sv | 29 ++
 rtl/addr_seq.sv | 122 ++++++++++++
 tb/tb_addr_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/addr_seq_pkg.sv
// Shared types and constants for the systolic-array serial-number sequencer.
// Also used by addr_sel for the serial-number width.
package addr_seq_pkg;

    localparam int SERIAL_W      = 7;
    localparam int STEP          = 4;
    localparam int DRAIN_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Serial numbers advance in steps of 4, so the two low bits carry no address.
    function automatic logic [SERIAL_W-1:0] align_num(input logic [SERIAL_W-1:0] num);
        return {num[SERIAL_W-1:2], 2'b00};
    endfunction

    function automatic logic is_aligned(input logic [SERIAL_W-1:0] num);
        return (num[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/drain_cnt.sv
// Loadable down-counter with a zero flag; it stops at zero and does not wrap.
module drain_cnt #(
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/addr_seq.sv
// Issues a range of serial numbers to addr_sel, drains the array, then pulses done.
// Optional ADDR_SEQ_ERR_EN: rejects misaligned ranges and adds the o_err pulse.
//
// state    | meaning
// ST_IDLE  | waiting for i_start
// ST_ISSUE | presenting one serial number per unstalled cycle
// ST_DRAIN | last number issued, letting operands flush through addr_sel and the skew
// ST_DONE  | one-cycle o_done pulse
module addr_seq
    import addr_seq_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_DEFAULT
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [SERIAL_W-1:0] i_first_num,
    input  logic [SERIAL_W-1:0] i_last_num,
    input  logic                i_stall,
    output logic [SERIAL_W-1:0] o_addr_serial_num,
    output logic                o_addr_valid,
    output logic                o_busy,
`ifdef ADDR_SEQ_ERR_EN
    output logic                o_done,
    output logic                o_err
`else
    output logic                o_done
`endif
);

    localparam int                CNT_W      = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    state_t              r_state;
    state_t              w_next;
    logic [SERIAL_W-1:0] r_serial;
    logic [SERIAL_W-1:0] r_last;
    logic                w_accept;
    logic                w_issue;
    logic                w_last_issue;
    logic                w_cnt_zero;
    logic [CNT_W-1:0]    w_cnt;

`ifdef ADDR_SEQ_ERR_EN
    logic r_err;
    logic w_reject;

    assign w_reject = (r_state == ST_IDLE) && i_start &&
                      !(is_aligned(i_first_num) && is_aligned(i_last_num));
    assign w_accept = (r_state == ST_IDLE) && i_start && !w_reject;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_reject;
        end
    end

    assign o_err = r_err;
`else
    assign w_accept = (r_state == ST_IDLE) && i_start;
`endif

    assign w_issue      = (r_state == ST_ISSUE) && !i_stall;
    assign w_last_issue = w_issue && (r_serial == r_last);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)     w_next = ST_ISSUE;
            ST_ISSUE: if (w_last_issue) w_next = ST_DRAIN;
            ST_DRAIN: if (w_cnt_zero)   w_next = ST_DONE;
            ST_DONE:                    w_next = ST_IDLE;
            default:                    w_next = ST_IDLE;
        endcase
    end

    // Without error checking the low bits are dropped so the +STEP walk always meets last.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_serial <= '0;
            r_last   <= '0;
        end else if (w_accept) begin
`ifdef ADDR_SEQ_ERR_EN
            r_serial <= i_first_num;
            r_last   <= i_last_num;
`else
            r_serial <= align_num(i_first_num);
            r_last   <= align_num(i_last_num);
`endif
        end else if (w_issue && !w_last_issue) begin
            r_serial <= r_serial + SERIAL_W'(STEP);
        end
    end

    drain_cnt #(
        .W (CNT_W)
    ) u_drain_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_last_issue),
        .i_load_val (DRAIN_LOAD),
        .i_dec      (r_state == ST_DRAIN),
        .o_cnt      (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    assign o_addr_serial_num = r_serial;
    assign o_addr_valid      = w_issue;
    assign o_busy            = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
    assign o_done            = (r_state == ST_DONE);

endmodule

// File: tb/tb_addr_seq.sv
// Directed, table-driven bench for addr_seq plus hand-written reset and error sequences.
// Build with ADDR_SEQ_ERR_EN defined to exercise the o_err path.
module tb_addr_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [6:0] first_num;
    logic [6:0] last_num;
    logic       stall;
    logic [6:0] addr_serial_num;
    logic       addr_valid;
    logic       busy;
    logic       done;
`ifdef ADDR_SEQ_ERR_EN
    logic       err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    addr_seq dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_start           (start),
        .i_first_num       (first_num),
        .i_last_num        (last_num),
        .i_stall           (stall),
        .o_addr_serial_num (addr_serial_num),
        .o_addr_valid      (addr_valid),
        .o_busy            (busy),
`ifdef ADDR_SEQ_ERR_EN
        .o_done            (done),
        .o_err             (err)
`else
        .o_done            (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] first;
        logic [6:0] last;
        int         stall_val;
        int         stall_len;
        bit         poke;
        int         exp_n;
        logic [6:0] exp_v0;
        logic [6:0] exp_vl;
        int         exp_done;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a sequence and watches it until o_done; cycle 1 is the cycle after the start edge.
    task automatic run_seq(input vec_t v, output int n, output logic [6:0] v0,
                           output logic [6:0] vl, output int done_cyc, output int bad);
        logic [6:0] prev;
        int         stalled;
        n        = 0;
        v0       = 'x;
        vl       = 'x;
        prev     = '0;
        done_cyc = -1;
        bad      = 0;
        stalled  = 0;
        start     = 1'b1;
        first_num = v.first;
        last_num  = v.last;
        step();
        start = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            stall = (int'(addr_serial_num) == v.stall_val) && (stalled < v.stall_len) && busy;
            start = v.poke && ((n == 3) || done);
            #1;
            if (stall) begin
                stalled++;
                if (addr_valid) bad++;
            end
            if (addr_valid) begin
                if (n == 0) v0 = addr_serial_num;
                else if (addr_serial_num != prev + 7'd4) bad++;
                prev = addr_serial_num;
                vl   = addr_serial_num;
                n++;
            end
            if (done) begin
                done_cyc = cyc;
                if (busy) bad++;
                break;
            end
            if (!busy) bad++;
            step();
        end
        stall = 1'b0;
        step();
        start = 1'b0;
        #1;
        chk("idle_after_done.busy", int'(busy), 0);
        chk("idle_after_done.done", int'(done), 0);
    endtask

    initial begin
        int         n;
        int         dc;
        int         bad;
        int         cnt;
        logic [6:0] v0;
        logic [6:0] vl;
        vec_t       v;

        vecs.push_back('{7'd0,   7'd28, -1, 0, 1'b0, 8, 7'd0,   7'd28, 25});
        vecs.push_back('{7'd0,   7'd28,  8, 3, 1'b0, 8, 7'd0,   7'd28, 28});
        vecs.push_back('{7'd124, 7'd4,  -1, 0, 1'b0, 3, 7'd124, 7'd4,  20});
        vecs.push_back('{7'd96,  7'd96, -1, 0, 1'b0, 1, 7'd96,  7'd96, 18});
        vecs.push_back('{7'd0,   7'd8,   8, 2, 1'b0, 3, 7'd0,   7'd8,  22});
        vecs.push_back('{7'd0,   7'd28, -1, 0, 1'b1, 8, 7'd0,   7'd28, 25});
        vecs.push_back('{7'd120, 7'd0,  -1, 0, 1'b0, 3, 7'd120, 7'd0,  20});
`ifndef ADDR_SEQ_ERR_EN
        vecs.push_back('{7'd5,   7'd14, -1, 0, 1'b0, 3, 7'd4,   7'd12, 20});
`endif

        rst_n     = 1'b0;
        start     = 1'b0;
        stall     = 1'b0;
        first_num = '0;
        last_num  = '0;
        repeat (3) step();
        chk("reset.addr", int'(addr_serial_num), 0);
        chk("reset.valid", int'(addr_valid), 0);
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            v = vecs[i];
            run_seq(v, n, v0, vl, dc, bad);
            chk($sformatf("vec%0d.count", i), n, v.exp_n);
            chk($sformatf("vec%0d.first", i), int'(v0), int'(v.exp_v0));
            chk($sformatf("vec%0d.last", i), int'(vl), int'(v.exp_vl));
            chk($sformatf("vec%0d.done_cycle", i), dc, v.exp_done);
            chk($sformatf("vec%0d.step_errs", i), bad, 0);
            step();
        end

        // Reset in the middle of DRAIN: outputs clear at once and no done follows.
        start     = 1'b1;
        first_num = 7'd40;
        last_num  = 7'd40;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("pre_reset.busy", int'(busy), 1);
        chk("pre_reset.addr", int'(addr_serial_num), 40);
        rst_n = 1'b0;
        step();
        chk("mid_reset.addr", int'(addr_serial_num), 0);
        chk("mid_reset.valid", int'(addr_valid), 0);
        chk("mid_reset.busy", int'(busy), 0);
        chk("mid_reset.done", int'(done), 0);
        rst_n = 1'b1;
        cnt   = 0;
        repeat (30) begin
            step();
            if (done || busy) cnt++;
        end
        chk("post_reset.activity", cnt, 0);
        v = '{7'd0, 7'd28, -1, 0, 1'b0, 8, 7'd0, 7'd28, 25};
        run_seq(v, n, v0, vl, dc, bad);
        chk("post_reset.count", n, 8);
        chk("post_reset.done_cycle", dc, 25);
        chk("post_reset.step_errs", bad, 0);

`ifdef ADDR_SEQ_ERR_EN
        step();
        start     = 1'b1;
        first_num = 7'd2;
        last_num  = 7'd8;
        step();
        start = 1'b0;
        chk("err.pulse", int'(err), 1);
        chk("err.busy", int'(busy), 0);
        cnt = 0;
        bad = 0;
        repeat (20) begin
            step();
            if (err) cnt++;
            if (addr_valid || busy) bad++;
        end
        chk("err.extra_pulses", cnt, 0);
        chk("err.activity", bad, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
